// File: rtl/score_keeper.sv
// score_keeper: turns ball-exit events into two score digits for the score
// board and paces play (serve delay, game over). Single clock domain.
// Optional build macro: SCORE_KEEPER_AUTO_RESTART_EN (OVER also exits on its
// own after 4*p_SERVE_DELAY clocks, for attract/kiosk mode).
module score_keeper #(
    parameter int unsigned p_WIN_SCORE   = 9,
    parameter int unsigned p_SERVE_DELAY = 12500000,
    parameter int unsigned p_CNT_W       = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Goal_L,
    input  logic       i_Goal_R,
    output logic [3:0] o_Score_P1,
    output logic [3:0] o_Score_P2,
    output logic       o_Serve,
    output logic       o_Playing,
    output logic       o_Game_Over,
    output logic       o_Winner
);

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    // Two extra bits so the counter can also time the 4x OVER timeout.
    localparam int unsigned CntW = p_CNT_W + 2;
    localparam logic [CntW-1:0] OverLast = CntW'(4 * p_SERVE_DELAY - 1);
`else
    localparam int unsigned CntW = p_CNT_W;
`endif
    localparam logic [CntW-1:0] ServeLast = CntW'(p_SERVE_DELAY - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [3:0]      WinScore  = 4'(p_WIN_SCORE);

    typedef enum logic [1:0] {StIdle, StServe, StPlay, StOver} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      p1_q, p1_d;
    logic [3:0]      p2_q, p2_d;
    logic            serve_q, serve_d;
    logic            winner_q, winner_d;
    logic            start_q, goal_l_q, goal_r_q;
    logic            start_rise, goal_l_rise, goal_r_rise;

    assign start_rise  = i_Start  & ~start_q;
    assign goal_l_rise = i_Goal_L & ~goal_l_q;
    assign goal_r_rise = i_Goal_R & ~goal_r_q;

    // State, scores, delay counter and edge-detect history.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            serve_q  <= 1'b0;
            winner_q <= 1'b0;
            start_q  <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            serve_q  <= serve_d;
            winner_q <= winner_d;
            start_q  <= i_Start;
            goal_l_q <= i_Goal_L;
            goal_r_q <= i_Goal_R;
        end
    end

    // Next-state logic: serve pacing, scoring and game-over decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        serve_d  = 1'b0;
        winner_d = winner_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d  = StServe;
                    cnt_d    = '0;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = 1'b0;
                end
            end
            StServe: begin
                // The serve pulse cycle is the last SERVE cycle; PLAY follows it.
                if (serve_q) begin
                    state_d = StPlay;
                end else if (cnt_q == ServeLast) begin
                    serve_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPlay: begin
                if (goal_l_rise && goal_r_rise) begin
                    // Simultaneous exits: nobody scores, serve again.
                    state_d = StServe;
                    cnt_d   = '0;
                end else if (goal_r_rise) begin
                    p1_d  = p1_q + 4'd1;
                    cnt_d = '0;
                    if (p1_q + 4'd1 == WinScore) begin
                        state_d  = StOver;
                        winner_d = 1'b0;
                    end else begin
                        state_d = StServe;
                    end
                end else if (goal_l_rise) begin
                    p2_d  = p2_q + 4'd1;
                    cnt_d = '0;
                    if (p2_q + 4'd1 == WinScore) begin
                        state_d  = StOver;
                        winner_d = 1'b1;
                    end else begin
                        state_d = StServe;
                    end
                end
            end
            StOver: begin
                if (start_rise) begin
                    state_d  = StServe;
                    cnt_d    = '0;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = 1'b0;
                end
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
                else if (cnt_q == OverLast) begin
                    state_d  = StServe;
                    cnt_d    = '0;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_Score_P1  = p1_q;
    assign o_Score_P2  = p2_q;
    assign o_Serve     = serve_q;
    assign o_Playing   = (state_q == StPlay);
    assign o_Game_Over = (state_q == StOver);
    assign o_Winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (p_SERVE_DELAY = 8). Stimulus pushes the
// expected output snapshots with the cycle they must appear; the monitor pops
// one whenever the DUT's visible outputs change.
module tb_score_keeper;
    localparam int unsigned D   = 8;
    localparam logic [3:0]  WIN = 4'd9;

    logic       clk = 1'b0;
    logic       rst, start, gl, gr;
    logic [3:0] p1, p2;
    logic       serve, playing, over, winner;

    score_keeper #(
        .p_WIN_SCORE  (9),
        .p_SERVE_DELAY(D),
        .p_CNT_W      (4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .i_Goal_L   (gl),
        .i_Goal_R   (gr),
        .o_Score_P1 (p1),
        .o_Score_P2 (p2),
        .o_Serve    (serve),
        .o_Playing  (playing),
        .o_Game_Over(over),
        .o_Winner   (winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       serve;
        logic       playing;
        logic       over;
        logic       winner;
        logic [3:0] p1;
        logic [3:0] p2;
    } snap_t;

    typedef struct packed {
        int    at;
        snap_t s;
    } exp_t;

    exp_t  q[$];
    snap_t last_exp, prev, cur;
    exp_t  e;
    logic [3:0] m_p1, m_p2;
    logic  m_over, m_win;
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 0;
    int    c_last;

    function automatic snap_t live();
        snap_t s;
        s.serve = serve; s.playing = playing; s.over = over; s.winner = winner;
        s.p1 = p1; s.p2 = p2;
        return s;
    endfunction

    function automatic snap_t mk(input logic sv, input logic pl);
        snap_t s;
        s.serve = sv; s.playing = pl; s.over = m_over; s.winner = m_win;
        s.p1 = m_p1; s.p2 = m_p2;
        return s;
    endfunction

    task automatic expect_at(input int at, input snap_t s);
        exp_t x;
        if (s != last_exp) begin
            x.at = at;
            x.s  = s;
            q.push_back(x);
            last_exp = s;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every visible output change must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = live();
            while (q.size() > 0 && q[0].at < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_event: expected snap %h at cycle %0d, not seen by %0d",
                         q[0].s, q[0].at, cyc);
                void'(q.pop_front());
            end
            if (cur !== prev) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got snap %h at cycle %0d, expected none",
                             cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.at != cyc || e.s !== cur) begin
                        n_fail++;
                        $display("FAIL event: got snap %h at cycle %0d, expected %h at cycle %0d",
                                 cur, cyc, e.s, e.at);
                    end
                end
                prev = cur;
            end
        end
    end

    // Start request; returns at the first PLAY cycle.
    task automatic do_start();
        int c;
        c = cyc;
        start = 1'b1;
        m_p1 = 4'd0; m_p2 = 4'd0; m_over = 1'b0; m_win = 1'b0;
        expect_at(c + 1, mk(1'b0, 1'b0));
        expect_at(c + 1 + D, mk(1'b1, 1'b0));
        expect_at(c + 2 + D, mk(1'b0, 1'b1));
        tick(1);
        start = 1'b0;
        tick(D + 1);
    endtask

    // Goal in PLAY; noise pulses both goals and start mid-SERVE (all ignored).
    task automatic goal(input bit l_v, input bit r_v, input int hold, input bit noise);
        int c;
        int el;
        c = cyc;
        gl = l_v;
        gr = r_v;
        if (l_v && !r_v) m_p2 = m_p2 + 4'd1;
        if (r_v && !l_v) m_p1 = m_p1 + 4'd1;
        if (m_p1 == WIN || m_p2 == WIN) begin
            m_over = 1'b1;
            m_win  = l_v;
            expect_at(c + 1, mk(1'b0, 1'b0));
            tick(hold);
            gl = 1'b0;
            gr = 1'b0;
        end else begin
            expect_at(c + 1, mk(1'b0, 1'b0));
            expect_at(c + 1 + D, mk(1'b1, 1'b0));
            expect_at(c + 2 + D, mk(1'b0, 1'b1));
            tick(hold);
            gl = 1'b0;
            gr = 1'b0;
            el = hold;
            if (noise) begin
                tick(1);
                gl = 1'b1; gr = 1'b1; start = 1'b1;
                tick(1);
                gl = 1'b0; gr = 1'b0; start = 1'b0;
                el += 2;
            end
            tick(D + 2 - el);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; gl = 1'b0; gr = 1'b0;
        m_p1 = 4'd0; m_p2 = 4'd0; m_over = 1'b0; m_win = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_p1", int'(p1), 0);
        chk("rst_p2", int'(p2), 0);
        chk("rst_serve", int'(serve), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_over", int'(over), 0);
        chk("rst_winner", int'(winner), 0);
        last_exp = '0;
        prev     = live();
        mon_en   = 1'b1;
        tick(2);
        chk("idle_playing", int'(playing), 0);

        do_start();
        goal(1'b0, 1'b1, 5, 1'b1);      // held goal scores once: 1/0
        goal(1'b1, 1'b1, 1, 1'b0);      // simultaneous: re-serve, 1/0
        for (int i = 0; i < 9; i++) goal(1'b1, 1'b0, 1, 1'b0);
        chk("over_flag", int'(over), 1);
        chk("over_winner", int'(winner), 1);
        chk("over_p2", int'(p2), 9);
        chk("over_p1", int'(p1), 1);

        // Goals in OVER leave everything frozen.
        gl = 1'b1; tick(2); gl = 1'b0;
        gr = 1'b1; tick(2); gr = 1'b0;
        tick(4);
        do_start();

        // Reset three clocks into SERVE cancels the pending serve.
        c = cyc;
        gr = 1'b1;
        m_p1 = 4'd1;
        expect_at(c + 1, mk(1'b0, 1'b0));
        tick(1);
        gr = 1'b0;
        tick(2);
        rst = 1'b1;
        m_p1 = 4'd0; m_p2 = 4'd0; m_over = 1'b0; m_win = 1'b0;
        expect_at(c + 4, mk(1'b0, 1'b0));
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("post_rst_p1", int'(p1), 0);
        chk("post_rst_playing", int'(playing), 0);
        chk("post_rst_serve", int'(serve), 0);

        // Second game: player 1 wins.
        do_start();
        c_last = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) c_last = cyc;
            goal(1'b0, 1'b1, 1, 1'b0);
        end
        chk("p1_win_over", int'(over), 1);
        chk("p1_win_winner", int'(winner), 0);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        m_p1 = 4'd0; m_p2 = 4'd0; m_over = 1'b0; m_win = 1'b0;
        expect_at(c_last + 1 + 4 * D, mk(1'b0, 1'b0));
        expect_at(c_last + 1 + 4 * D + D, mk(1'b1, 1'b0));
        expect_at(c_last + 2 + 4 * D + D, mk(1'b0, 1'b1));
        tick(4 * D + D + 2);
        chk("auto_restart_playing", int'(playing), 1);
        chk("auto_restart_p1", int'(p1), 0);
`else
        tick(100);
        chk("still_over", int'(over), 1);
        chk("still_over_p1", int'(p1), 9);
`endif
        tick(3);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
